// File: rtl/result_collector_pkg.sv
// Shared types and helpers for the result collector: FSM state encoding and
// the index-width function used to size row/address/count fields.
package result_collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Ceiling log2, never below 1 so that degenerate sizes still get a real bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/result_bank.sv
// One lane's result storage: write port, asynchronous read port and per-entry
// written bits; unwritten entries read back as zero.
module result_bank
    import result_collector_pkg::*;
#(
    parameter int value_size    = 32,
    parameter int rows_per_lane = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              we,
    input  logic [clog2(rows_per_lane)-1:0]   waddr,
    input  logic [value_size-1:0]             wdata,
    input  logic [clog2(rows_per_lane)-1:0]   raddr,
    output logic [value_size-1:0]             rdata
);

    logic [value_size-1:0]    mem [rows_per_lane];
    logic [rows_per_lane-1:0] written;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Data is never reset; only these bits decide whether an entry is visible.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            written <= '0;
        end else if (we) begin
            written[waddr] <= 1'b1;
        end
    end

    assign rdata = written[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/result_collector.sv
// Gathers per-lane adder results into interleaved banks, then streams every
// global row out in order under valid/ready handshake.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int N             = 2,
    parameter int value_size    = 32,
    parameter int rows_per_lane = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N*value_size-1:0]             ans,
    input  logic [N-1:0]                        ready,
    input  logic                                flush,
    output logic [value_size-1:0]               out_val,
    output logic [clog2(N*rows_per_lane)-1:0]   out_row,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                lost
);

    localparam int RW       = clog2(N * rows_per_lane);
    localparam int AW       = clog2(rows_per_lane);
    localparam int CW       = clog2(rows_per_lane + 1);
    localparam int LAST_ROW = N * rows_per_lane - 1;

    state_t                state, state_nxt;
    logic [N-1:0]          we;
    logic [value_size-1:0] rd_data [N];
    logic [AW-1:0]         raddr;
    logic [RW-1:0]         row_q;
    logic                  accept;
    logic                  last_accept;
    logic                  done_q;
    logic                  lost_q;

    assign accept      = (state == DRAIN) && out_ready;
    assign last_accept = accept && (row_q == RW'(LAST_ROW));

    // Global row r lives in bank r mod N at address r div N.
    assign raddr = AW'(32'(row_q) / 32'(N));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (flush)       state_nxt = DRAIN;
            DRAIN:   if (last_accept) state_nxt = COLLECT;
            default:                  state_nxt = COLLECT;
        endcase
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [CW-1:0] cnt;

        assign we[k] = ready[k] && (state == COLLECT) && (cnt < CW'(rows_per_lane));

        always_ff @(posedge clk) begin
            if (rst || last_accept) begin
                cnt <= '0;
            end else if (we[k]) begin
                cnt <= cnt + CW'(1);
            end
        end

        result_bank #(
            .value_size    (value_size),
            .rows_per_lane (rows_per_lane)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .clr   (last_accept),
            .we    (we[k]),
            .waddr (AW'(cnt)),
            .wdata (ans[k*value_size +: value_size]),
            .raddr (raddr),
            .rdata (rd_data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            done_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            done_q <= last_accept;
            if (last_accept) begin
                row_q <= '0;
            end else if (accept) begin
                row_q <= row_q + RW'(1);
            end
            // Any strobe that did not turn into a write was a dropped result.
            if (|(ready & ~we)) begin
                lost_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_val = '0;
        if (state == DRAIN) begin
            for (int k = 0; k < N; k++) begin
                if ((32'(row_q) % 32'(N)) == 32'(k)) begin
                    out_val = rd_data[k];
                end
            end
        end
    end

    assign out_row   = row_q;
    assign out_valid = (state == DRAIN);
    assign busy      = (state == DRAIN);
    assign done      = done_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with default parameters (2 lanes x 8 rows).
module tb_result_collector;

    logic        clk;
    logic        rst;
    logic [63:0] ans;
    logic [1:0]  ready;
    logic        flush;
    logic [31:0] out_val;
    logic [3:0]  out_row;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        lost;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rows [16];

    typedef struct {
        logic [1:0]  rdy;
        logic [63:0] data;
        logic        fl;
        logic        ordy;
        logic        e_valid;
        logic [3:0]  e_row;
        logic [31:0] e_val;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl [19];

    result_collector #(
        .N             (2),
        .value_size    (32),
        .rows_per_lane (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ans       (ans),
        .ready     (ready),
        .flush     (flush),
        .out_val   (out_val),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 required");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1);
        ready = r;
        ans   = {a1, a0};
        tick();
        ready = 2'b00;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp_rows[i] = 32'h0;
    endtask

    // Accept all 16 rows, optionally holding out_ready low at one row.
    task automatic drain_check(input string tag, input int stall_row, input int stall_cycles,
                               input logic exp_lost);
        for (int r = 0; r < 16; r++) begin
            if (r == stall_row) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    out_ready = 1'b0;
                    chk($sformatf("%s stall%0d row", tag, s), 32'(out_row), 32'(r));
                    chk($sformatf("%s stall%0d val", tag, s), out_val, exp_rows[r]);
                    tick();
                end
            end
            chk($sformatf("%s r%0d valid", tag, r), 32'(out_valid), 32'd1);
            chk($sformatf("%s r%0d row", tag, r), 32'(out_row), 32'(r));
            chk($sformatf("%s r%0d val", tag, r), out_val, exp_rows[r]);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " valid_end"}, 32'(out_valid), 32'd0);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " lost"}, 32'(lost), 32'(exp_lost));
        tick();
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ans = '0; ready = 2'b00; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst val", out_val, 32'h0);
        chk("rst row", 32'(out_row), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst lost", 32'(lost), 32'd0);

        // Both lanes in one cycle, then a full continuous drain.
        tbl[0] = '{2'b11, {32'h408d1eb8, 32'h3f9ae148}, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{2'b00, 64'h0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h3f9ae148, 1'b1, 1'b0};
        for (int r = 1; r < 16; r++) begin
            tbl[r+1] = '{2'b00, 64'h0, 1'b0, 1'b1, 1'b1, 4'(r),
                         (r == 1) ? 32'h408d1eb8 : 32'h0, 1'b1, 1'b0};
        end
        tbl[17] = '{2'b00, 64'h0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1};
        tbl[18] = '{2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 19; i++) begin
            ready = tbl[i].rdy; ans = tbl[i].data; flush = tbl[i].fl; out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d row", i), 32'(out_row), 32'(tbl[i].e_row));
            chk($sformatf("v%0d val", i), out_val, tbl[i].e_val);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d lost", i), 32'(lost), 32'd0);
        end
        ready = 2'b00; flush = 1'b0; out_ready = 1'b0;

        // Three lane0 results, the last coinciding with flush.
        push(2'b01, 32'h40000000, 32'h0);
        push(2'b01, 32'h40400000, 32'h0);
        ready = 2'b01; ans = {32'h0, 32'h40800000}; flush = 1'b1;
        tick();
        ready = 2'b00; flush = 1'b0;
        clear_exp();
        exp_rows[0] = 32'h40000000; exp_rows[2] = 32'h40400000; exp_rows[4] = 32'h40800000;
        drain_check("seq3", -1, 0, 1'b0);

        // Back-pressure held at row 3.
        clear_exp();
        for (int a = 0; a < 4; a++) begin
            push(2'b11, 32'h11110000 + 32'(a), 32'h22220000 + 32'(a));
            exp_rows[2*a]   = 32'h11110000 + 32'(a);
            exp_rows[2*a+1] = 32'h22220000 + 32'(a);
        end
        do_flush();
        drain_check("stall", 3, 5, 1'b0);

        // Lane1 overflow: ninth pulse dropped, lost sticky until rst.
        clear_exp();
        for (int i = 0; i < 9; i++) begin
            push(2'b10, 32'h0, 32'h50000000 + 32'(i));
            if (i < 8) exp_rows[2*i+1] = 32'h50000000 + 32'(i);
            if (i == 7) chk("ovf lost_before", 32'(lost), 32'd0);
        end
        chk("ovf lost_after", 32'(lost), 32'd1);
        do_flush();
        drain_check("ovf", -1, 0, 1'b1);
        chk("ovf lost_sticky", 32'(lost), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf lost_cleared", 32'(lost), 32'd0);

        // Strobe during DRAIN is dropped; next round starts from empty banks.
        push(2'b01, 32'hAAAA0001, 32'h0);
        do_flush();
        ready = 2'b01; ans = {32'h0, 32'hBBBB0002};
        tick();
        ready = 2'b00;
        chk("drn lost", 32'(lost), 32'd1);
        chk("drn row_held", 32'(out_row), 32'd0);
        clear_exp();
        exp_rows[0] = 32'hAAAA0001;
        drain_check("drn1", -1, 0, 1'b1);
        push(2'b01, 32'hCCCC0003, 32'h0);
        do_flush();
        clear_exp();
        exp_rows[0] = 32'hCCCC0003;
        drain_check("drn2", -1, 0, 1'b1);

        // Reset mid-drain at row 6, colliding with every other input.
        push(2'b10, 32'h0, 32'hDDDD0004);
        do_flush();
        chk("mid lost_pre", 32'(lost), 32'd1);
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) tick();
        chk("mid row6", 32'(out_row), 32'd6);
        rst = 1'b1; ready = 2'b11; ans = 64'hFFFF0005FFFF0006; flush = 1'b1;
        tick();
        rst = 1'b0; ready = 2'b00; flush = 1'b0; out_ready = 1'b0;
        chk("mid valid", 32'(out_valid), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid lost", 32'(lost), 32'd0);
        chk("mid done", 32'(done), 32'd0);
        chk("mid row", 32'(out_row), 32'd0);
        do_flush();
        clear_exp();
        drain_check("mid", -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
